// File: rtl/mips_mem_arbiter_if.sv
// Shared SRAM-like memory port between the arbiter (master)
// and the memory bridge (slave).
interface mips_mem_arbiter_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req,
        output wr,
        output size,
        output addr,
        output wdata,
        input  addr_ok,
        input  data_ok,
        input  rdata
    );

    modport slave (
        input  req,
        input  wr,
        input  size,
        input  addr,
        input  wdata,
        output addr_ok,
        output data_ok,
        output rdata
    );
endinterface

// File: rtl/mips_mem_arbiter.sv
// Shares one SRAM-like port between fetch and memory stage: data first,
// with a bounded starvation counter so fetch always makes progress.
module mips_mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               inst_req,
    input  logic [31:0]        inst_addr,
    output logic               inst_addr_ok,
    output logic               inst_data_ok,
    output logic [31:0]        inst_rdata,
    input  logic               data_req,
    input  logic               data_wr,
    input  logic [1:0]         data_size,
    input  logic [31:0]        data_addr,
    input  logic [31:0]        data_wdata,
    output logic               data_addr_ok,
    output logic               data_data_ok,
    output logic [31:0]        data_rdata,
    output logic               busy,
    mips_mem_arbiter_if.master mem
);
    localparam logic [2:0] LIMIT    = 3'(STARVE_LIMIT);
    localparam logic       OWN_INST = 1'b0;
    localparam logic       OWN_DATA = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic        owner_q;
    logic        owner_d;
    logic [2:0]  starve_q;
    logic [2:0]  starve_d;
    logic        wr_q;
    logic        wr_d;
    logic [1:0]  size_q;
    logic [1:0]  size_d;
    logic [31:0] addr_q;
    logic [31:0] addr_d;
    logic [31:0] wdata_q;
    logic [31:0] wdata_d;

    logic        any_req;
    logic        grant_inst;
    logic        starve_hit;
    logic [2:0]  starve_inc;

    assign any_req    = inst_req | data_req;
    assign starve_hit = (starve_q == LIMIT);
    assign grant_inst = inst_req & (~data_req | starve_hit);
    assign starve_inc = starve_hit ? starve_q : starve_q + 3'd1;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= IDLE;
            owner_q  <= OWN_INST;
            starve_q <= 3'd0;
            wr_q     <= 1'b0;
            size_q   <= 2'd0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            starve_q <= starve_d;
            wr_q     <= wr_d;
            size_q   <= size_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        starve_d     = starve_q;
        wr_d         = wr_q;
        size_d       = size_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        mem.req      = 1'b0;
        inst_addr_ok = 1'b0;
        data_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        data_data_ok = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = ADDR;
                    if (grant_inst) begin
                        owner_d  = OWN_INST;
                        starve_d = 3'd0;
                        wr_d     = 1'b0;
                        size_d   = 2'd2;
                        addr_d   = inst_addr;
                        wdata_d  = 32'd0;
                    end else begin
                        owner_d  = OWN_DATA;
                        // only counts while fetch is actually waiting
                        starve_d = inst_req ? starve_inc : 3'd0;
                        wr_d     = data_wr;
                        size_d   = data_size;
                        addr_d   = data_addr;
                        wdata_d  = data_wdata;
                    end
                end
            end
            ADDR: begin
                mem.req      = 1'b1;
                inst_addr_ok = mem.addr_ok & (owner_q == OWN_INST);
                data_addr_ok = mem.addr_ok & (owner_q == OWN_DATA);
                if (mem.addr_ok) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                inst_data_ok = mem.data_ok & (owner_q == OWN_INST);
                data_data_ok = mem.data_ok & (owner_q == OWN_DATA);
                if (mem.data_ok) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign mem.wr     = wr_q;
    assign mem.size   = size_q;
    assign mem.addr   = addr_q;
    assign mem.wdata  = wdata_q;
    assign inst_rdata = mem.rdata;
    assign data_rdata = mem.rdata;
    assign busy       = (state_q != IDLE);
endmodule

// File: doc/mips_mem_arbiter.md
# mips_mem_arbiter

Shares the single SRAM-like memory port between the fetch stage (instruction requester) and the memory stage (data requester). It sits between the pipeline and the memory bridge, with one transaction outstanding at a time. Data requests have priority over instruction requests, and a bounded starvation counter guarantees forward progress for fetch. Each response is routed back to the requester that issued it.

## Interface
Parameters:
- `STARVE_LIMIT`, default 4: maximum consecutive data grants while `inst_req` is pending before one instruction grant is forced. Legal range 1–7.

Ports:
- `clk`  in  1: clock, all logic on rising edge.
- `resetn`  in  1: reset, synchronous, active-low.
- `inst_req`  in  1: fetch request; held high until `inst_addr_ok`.
- `inst_addr`  in  32: fetch address; stable while `inst_req` is high.
- `inst_addr_ok`  out  1: fetch address accepted by memory.
- `inst_data_ok`  out  1: fetch read data valid.
- `inst_rdata`  out  32: fetch read data.
- `data_req`  in  1: data request; held high until `data_addr_ok`.
- `data_wr`  in  1: 1 = write, 0 = read.
- `data_size`  in  2: 0 = byte, 1 = half, 2 = word.
- `data_addr`  in  32: data address.
- `data_wdata`  in  32: write data.
- `data_addr_ok`  out  1: data address accepted.
- `data_data_ok`  out  1: data transaction complete (read data valid, or write acknowledged).
- `data_rdata`  out  32: data read data.
- `mem_req`, `mem_wr`  out  1 each: shared-port request and write flag.
- `mem_size`  out  2: shared-port transfer size.
- `mem_addr`, `mem_wdata`  out  32 each: shared-port address and write data.
- `mem_addr_ok`, `mem_data_ok`  in  1 each: shared-port handshakes.
- `mem_rdata`  in  32: shared-port read data.
- `busy`  out  1: state is not IDLE.

## Operation
- FSM has three states: IDLE, ADDR, DATA. A 1-bit `owner` register records the requester: 0 = inst, 1 = data.
- **IDLE**
  - If no request is pending, stay in IDLE.
  - Otherwise grant one requester and go to ADDR.
  - On grant, latch `mem_wr`/`mem_size`/`mem_addr`/`mem_wdata` from the granted requester.
  - An instruction grant always latches wr = 0, size = 2, wdata = 0.
- **Grant rule**
  - Only `data_req` pending: grant data.
  - Only `inst_req` pending: grant inst.
  - Both pending: grant inst if `starve_cnt == STARVE_LIMIT`, otherwise grant data.
- **starve_cnt** (3 bits)
  - Increments on a data grant made while `inst_req` = 1, saturating at `STARVE_LIMIT`.
  - Clears to 0 on any instruction grant.
  - Clears to 0 on a data grant made while `inst_req` = 0.
- **ADDR**
  - `mem_req` = 1, driven from the latched registers.
  - `mem_addr_ok` is forwarded combinationally to the owner's `*_addr_ok`; the non-owner sees 0.
  - On `mem_addr_ok`, go to DATA.
- **DATA**
  - `mem_req` = 0.
  - `mem_data_ok` is forwarded combinationally to the owner's `*_data_ok`.
  - `mem_rdata` is passed to both `*_rdata` (meaningful only for the owner).
  - On `mem_data_ok`, go to IDLE.
- `mem_data_ok` in IDLE or ADDR is spurious: it is ignored and never forwarded.
- `*_addr_ok` and `*_data_ok` are 0 in every state except as stated above.
- Reset (resetn = 0 at a clock edge), including mid-transaction:
  - state → IDLE, `owner` = 0, `starve_cnt` = 0, latched fields = 0.
  - Any in-flight transaction is abandoned; the memory bridge is reset by the same `resetn`.

## Timing
- Reset values: `mem_req`/`mem_wr` = 0, `mem_size` = 0, `mem_addr`/`mem_wdata` = 0, all `*_addr_ok`/`*_data_ok` = 0, `busy` = 0.
- Request sampled in IDLE at edge T → `mem_req` = 1 and `busy` = 1 from cycle T+1.
- Owner's `*_addr_ok` coincides with `mem_addr_ok` (0-cycle pass-through).
- Owner's `*_data_ok` and `*_rdata` coincide with `mem_data_ok` and `mem_rdata`.
- Back-to-back transactions:
  - `mem_data_ok` in cycle D → IDLE in D+1 → next `mem_req` in D+2.
  - Minimum 3 cycles per transaction with a zero-wait slave.
- A requester that drops `*_req` after grant but before `*_addr_ok` is a protocol violation. The transaction still completes using the latched values.

## Test plan
- **Single fetch:** `inst_req` = 1 with `inst_addr` = 0xBFC00000 in IDLE; slave gives `addr_ok` 1 cycle after `mem_req` and `data_ok` 1 cycle later with 0x3C080001.
  - Expect `mem_addr` = 0xBFC00000, `mem_wr` = 0, `mem_size` = 2.
  - Expect `inst_data_ok` pulse with `inst_rdata` = 0x3C080001.
  - Expect `data_data_ok` = 0 throughout.
- **Data write priority:** `inst_req` and `data_req` (wr = 1, size = 0, addr = 0x80000003, wdata = 0xAB) rise in the same cycle.
  - Expect data granted first: `mem_wr` = 1, `mem_size` = 0, `mem_addr` = 0x80000003.
  - Expect the inst transaction to follow; its `mem_req` rises 2 cycles after data's `data_ok`.
- **Starvation bound:** hold `inst_req` and `data_req` continuously, `STARVE_LIMIT` = 4.
  - Expect grant order D, D, D, D, I, D, D, D, D, I.
- **Spurious data_ok:** pulse `mem_data_ok` in IDLE and again in ADDR.
  - Expect no `*_data_ok` pulse and no state change.
- **Reset mid-transaction:** drive `resetn` = 0 in DATA state for one cycle.
  - Expect `busy` = 0, `mem_req` = 0, all handshake outputs 0 on the next cycle.
  - Expect a new `inst_req` to be granted normally afterwards.
- **Wait-state slave:** `addr_ok` delayed 3 cycles, `data_ok` delayed 5 cycles.
  - Expect `mem_req` and `mem_addr` stable until `addr_ok`.
  - Expect exactly one `*_addr_ok` and one `*_data_ok` pulse, both to the owner.
